// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a simple req/ack handshake.
//
// Optional feature: define MEM_MISALIGN_ERR_EN to flag misaligned accesses.
// A flagged access is not performed: it writes nothing, returns rdata=0 and
// raises err with ack. Without the macro, err is tied low and the low
// address bits a half or word access cannot use are silently dropped.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states inserted before each access completes (0..15)
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous active-high reset (memory contents are kept)
//   req     access request, accepted only while idle
//   wren    1 = store, 0 = load (captured with req)
//   addr    byte address (captured with req, wraps modulo 4*DEPTH_WORDS)
//   funct3  RV32I load/store width code (captured with req)
//   wdata   store data, LSB-aligned (captured with req)
//   rdata   load result, extended per funct3; 0 whenever ack is low
//   ack     one-cycle completion pulse
//   busy    high while an access is in flight (WAIT or ACK)
//   err     misaligned-access fault, valid with ack; 0 whenever ack is low
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wren,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_wren;
  logic [AW+1:0]   cap_addr;
  logic [2:0]      cap_funct3;
  logic [31:0]     cap_wdata;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic            do_access;
  logic            fault;
  logic            mem_we;
  logic [3:0]      st_be;
  logic [31:0]     st_data;
  logic            unused_addr_bits;

  // Address bits above the memory size only exist to wrap the address space.
  assign unused_addr_bits = ^addr[31:AW+2];

  // Load result extraction: select the lane and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [2:0]  f3);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h   = a[1] ? word[31:16] : word[15:0];
    b_s = b;
    h_s = h;
    case (f3)
      3'b000:  return 32'(b_s);
      3'b001:  return 32'(h_s);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data onto every lane; byte enables pick the target.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

`ifdef MEM_MISALIGN_ERR_EN
  // Byte accesses never fault; halves need addr[0]=0; everything else is a word.
  function automatic logic misaligned(input logic w, input logic [2:0] f3, input logic [1:0] a);
    logic is_byte;
    logic is_half;
    is_byte = w ? (f3 == 3'b000) : (f3 == 3'b000 || f3 == 3'b100);
    is_half = w ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
    if (is_byte)      return 1'b0;
    else if (is_half) return a[0];
    else              return a != 2'b00;
  endfunction

  assign fault = misaligned(cap_wren, cap_funct3, cap_addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  assign idx       = cap_addr[AW+1:2];
  assign do_access = (state == WAIT) && (cnt == 4'd0);
  // Gating with reset is what makes a reset in WAIT abandon the store.
  assign mem_we    = do_access && cap_wren && !fault && !reset;
  assign st_be     = store_be(cap_funct3, cap_addr[1:0]);
  assign st_data   = store_lanes(cap_funct3, cap_wdata);

  // Request capture: only while idle, so a req during WAIT/ACK is dropped.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      cap_wren   <= wren;
      cap_addr   <= addr[AW+1:0];
      cap_funct3 <= funct3;
      cap_wdata  <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      rdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack   <= 1'b0;
          rdata <= 32'd0;
          err   <= 1'b0;
          if (req) begin
            state <= WAIT;
            busy  <= 1'b1;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Loads read the array in the same edge any earlier store has
            // already landed, so there is no stale read path.
            state <= ACK;
            ack   <= 1'b1;
            err   <= fault;
            rdata <= (cap_wren || fault) ? 32'd0
                                         : load_extract(mem[idx], cap_addr[1:0], cap_funct3);
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
          rdata <= 32'd0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          ack   <= 1'b0;
          busy  <= 1'b0;
          rdata <= 32'd0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, added wait states before each access completes; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  access request from the core-side initiator.
REQ-006 wren  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 funct3  input  3  RV32I load/store width code; sampled with req.
REQ-009 wdata  input  32  store data, LSB-aligned; sampled with req.
REQ-010 rdata  output  32  load result, sign- or zero-extended per funct3; valid while ack=1.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err  output  1  access-fault flag, valid while ack=1.

Function
REQ-014 States: IDLE, WAIT, ACK.
REQ-015 IDLE with req=1: capture wren/addr/funct3/wdata into internal registers; load wait counter with WAIT_CYCLES; go to WAIT.
REQ-016 IDLE with req=0: remain in IDLE.
REQ-017 WAIT with counter>0: decrement counter; remain in WAIT.
REQ-018 WAIT with counter=0: perform the access using the captured values; go to ACK.
REQ-019 ACK: assert ack=1 for exactly one cycle; next state is IDLE.
REQ-020 Latency: ack is high WAIT_CYCLES+2 cycles after the rising edge that accepted req (WAIT_CYCLES=0 gives ack on the 2nd cycle).
REQ-021 req while busy=1 is ignored and never queued; the initiator re-presents it after ack.
REQ-022 req=1 in the ACK cycle is ignored; a new request is accepted only from IDLE.
REQ-023 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
REQ-024 Loads: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend; any other code behaves as LW.
REQ-025 Stores: 000 SB writes byte lane addr[1:0] from wdata[7:0]; 001 SH writes half lane addr[1] from wdata[15:0]; 010 and any other code write the full word; unwritten lanes are unchanged.
REQ-026 A store presents rdata=0 during its ack cycle.
REQ-027 rdata is 0 whenever ack=0.
REQ-028 err is 0 whenever ack=0.
REQ-029 A load issued after a store completes returns the stored data; there is no stale read path.

Reset
REQ-030 reset=1 forces state IDLE, counter 0, ack=0, busy=0, rdata=0 and err=0 on the next edge.
REQ-031 reset overrides req in the same cycle; no request is accepted.
REQ-032 reset in WAIT abandons the access; a store that has not yet reached counter=0 is never written.
REQ-033 Memory contents are not cleared by reset.

Configuration
REQ-034 Macro MEM_MISALIGN_ERR_EN controls misaligned-access fault checking.
REQ-035 With MEM_MISALIGN_ERR_EN defined, an access is misaligned when it is LH/LHU/SH with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-036 With MEM_MISALIGN_ERR_EN defined, a misaligned access performs no write, returns rdata=0, and asserts err=1 with ack; timing is unchanged.
REQ-037 Without MEM_MISALIGN_ERR_EN, err is tied to 0 and the ignored low address bits are dropped (word: addr[1:0]; half: addr[0]).

Verification
REQ-038 WAIT_CYCLES=1: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> each ack arrives 3 cycles after req acceptance; the load returns rdata=0xDEADBEEF.
REQ-039 After REQ-038: SB 0x80 to 0x11; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-040 SH 0x8001 to 0x12; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; with DEPTH_WORDS=1024, LW 0x1010 -> same word as LW 0x10 (wrap).
REQ-041 req held high for 10 cycles with WAIT_CYCLES=0 -> exactly 3 acks (cycles 2, 5, 8 relative to first acceptance); busy is never low in the same cycle that ack is high.
REQ-042 SW 0x12345678 to 0x20, with reset asserted in its first WAIT cycle; after reset, LW 0x20 -> old value unchanged; ack is never pulsed for the aborted store.
REQ-043 MEM_MISALIGN_ERR_EN defined: SW 0xFFFFFFFF to 0x22 -> ack with err=1 and memory unchanged; without the macro, the same store writes word 0x20 and err=0.
